// File: rtl/rle_pkg.sv
// rtl/rle_pkg.sv - shared RLE types and DPSRAM port constants
package rle_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_UNPACK,
        ST_EXPAND,
        ST_WR,
        ST_FLUSH,
        ST_DONE
    } state_t;

    localparam int RLE_MAX_RUN    = 255;
    localparam int BYTES_PER_WORD = 4;
    localparam int DPSRAM_DATA_W  = 32;
    localparam int DPSRAM_ADDR_W  = 16;
    localparam int DPSRAM_BYTE_W  = 8;

endpackage

// File: rtl/rle_byte_packer.sv
// rtl/rle_byte_packer.sv - accumulates decoded bytes into little-endian words
module rle_byte_packer
    import rle_pkg::*;
(
    input  logic                     clk,
    input  logic                     nreset,
    input  logic                     push,
    input  logic [DPSRAM_BYTE_W-1:0] push_byte,
    input  logic                     drain,
    output logic [DPSRAM_DATA_W-1:0] word,
    output logic                     word_full,
    output logic                     flush
);

    logic [DPSRAM_DATA_W-1:0] data_q, data_d;
    logic [2:0]               cnt_q, cnt_d;

    // Drain zeroes the word so unused upper lanes of a partial word read as zero
    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (drain) begin
            data_d = '0;
            cnt_d  = '0;
        end else if (push && cnt_q != 3'd4) begin
            data_d[{cnt_q[1:0], 3'b000} +: DPSRAM_BYTE_W] = push_byte;
            cnt_d = cnt_q + 3'd1;
        end
    end

    // Accumulator registers
    always_ff @(posedge clk) begin
        if (!nreset) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    // word_full looks ahead: it is high in the cycle whose push completes the word
    assign word      = data_q;
    assign word_full = (cnt_q == 3'd4) || (push && cnt_q == 3'd3);
    assign flush     = (cnt_q != 3'd0);

endmodule

// File: rtl/rle_decoder.sv
// rtl/rle_decoder.sv - RLE (count,value) stream decoder over a DPSRAM port; RLE_DEC_ERR_CHECK_EN adds error output
module rle_decoder
    import rle_pkg::*;
#(
    parameter int ADDR_W        = 16,
    parameter int MAX_OUT_BYTES = 65535
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              start,
    input  logic [31:0]       rle_addr,
    input  logic [31:0]       rle_size,
    input  logic [31:0]       message_addr,
    output logic [31:0]       message_size,
    output logic              done,
    output logic              port_A_clk,
    output logic [ADDR_W-1:0] port_A_addr,
    output logic              port_A_we,
    output logic [31:0]       port_A_data_in,
    input  logic [31:0]       port_A_data_out
`ifdef RLE_DEC_ERR_CHECK_EN
    ,
    output logic              error
`endif
);

    localparam logic [31:0] MAX_OUT = 32'(MAX_OUT_BYTES);
    localparam logic [31:0] WORD_B  = 32'(BYTES_PER_WORD);

    state_t      state_q, state_d;
    logic [31:0] rle_base_q, rle_base_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [31:0] end_q, end_d;
    logic [31:0] sbyte_q, sbyte_d;
    logic [31:0] word_q, word_d;
    logic [31:0] out_cnt_q, out_cnt_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  val_q, val_d;
    logic [7:0]  run_q, run_d;
    logic        have_cnt_q, have_cnt_d;
    logic        start_ok, push, drain;
    logic [7:0]  cur_byte;
    logic [31:0] pk_word;
    logic        pk_word_full, pk_flush;

    // Where to go once the current pair is finished: read, keep unpacking, or end
    function automatic state_t src_next(input logic [31:0] ptr, input logic [31:0] stop,
                                        input logic partial);
        if (ptr >= stop)            return partial ? ST_FLUSH : ST_DONE;
        else if (ptr[1:0] == 2'b00) return ST_RD_REQ;
        else                        return ST_UNPACK;
    endfunction

    assign cur_byte = word_q[{sbyte_q[1:0], 3'b000} +: 8];
    assign drain    = start_ok || state_q == ST_WR || state_q == ST_FLUSH;

    rle_byte_packer u_packer (
        .clk       (clk),
        .nreset    (nreset),
        .push      (push),
        .push_byte (val_q),
        .drain     (drain),
        .word      (pk_word),
        .word_full (pk_word_full),
        .flush     (pk_flush)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q    <= ST_IDLE;
            rle_base_q <= '0;
            wr_addr_q  <= '0;
            end_q      <= '0;
            sbyte_q    <= '0;
            word_q     <= '0;
            out_cnt_q  <= '0;
            cnt_q      <= '0;
            val_q      <= '0;
            run_q      <= '0;
            have_cnt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rle_base_q <= rle_base_d;
            wr_addr_q  <= wr_addr_d;
            end_q      <= end_d;
            sbyte_q    <= sbyte_d;
            word_q     <= word_d;
            out_cnt_q  <= out_cnt_d;
            cnt_q      <= cnt_d;
            val_q      <= val_d;
            run_q      <= run_d;
            have_cnt_q <= have_cnt_d;
        end
    end

    // Next state and datapath: one stream byte per UNPACK cycle, one output byte per EXPAND cycle
    always_comb begin
        state_d    = state_q;
        rle_base_d = rle_base_q;
        wr_addr_d  = wr_addr_q;
        end_d      = end_q;
        sbyte_d    = sbyte_q;
        word_d     = word_q;
        out_cnt_d  = out_cnt_q;
        cnt_d      = cnt_q;
        val_d      = val_q;
        run_d      = run_q;
        have_cnt_d = have_cnt_q;
        start_ok   = 1'b0;
        push       = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    start_ok   = 1'b1;
                    rle_base_d = rle_addr;
                    wr_addr_d  = message_addr;
                    end_d      = {rle_size[31:1], 1'b0};
                    sbyte_d    = '0;
                    out_cnt_d  = '0;
                    run_d      = '0;
                    have_cnt_d = 1'b0;
                    state_d    = (rle_size < 32'd2) ? ST_DONE : ST_RD_REQ;
                end
            end
            ST_RD_REQ:  state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                word_d  = port_A_data_out;
                state_d = ST_UNPACK;
            end
            ST_UNPACK: begin
                sbyte_d = sbyte_q + 32'd1;
                if (!have_cnt_q) begin
                    cnt_d      = cur_byte;
                    have_cnt_d = 1'b1;
                    state_d    = src_next(sbyte_q + 32'd1, end_q, pk_flush);
                end else begin
                    val_d      = cur_byte;
                    have_cnt_d = 1'b0;
                    if (cnt_q == 8'd0) begin
                        state_d = src_next(sbyte_q + 32'd1, end_q, pk_flush);
                    end else begin
                        run_d   = cnt_q;
                        state_d = ST_EXPAND;
                    end
                end
            end
            ST_EXPAND: begin
                push      = 1'b1;
                run_d     = run_q - 8'd1;
                out_cnt_d = out_cnt_q + 32'd1;
                if (pk_word_full)           state_d = ST_WR;
                else if (out_cnt_d == MAX_OUT) state_d = ST_FLUSH;
                else if (run_q == 8'd1)     state_d = src_next(sbyte_q, end_q, 1'b1);
            end
            ST_WR: begin
                wr_addr_d = wr_addr_q + WORD_B;
                if (out_cnt_q == MAX_OUT) state_d = ST_DONE;
                else if (run_q != 8'd0)   state_d = ST_EXPAND;
                else                      state_d = src_next(sbyte_q, end_q, 1'b0);
            end
            ST_FLUSH: begin
                wr_addr_d = wr_addr_q + WORD_B;
                state_d   = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Memory port and status outputs decoded from the current state
    always_comb begin
        port_A_addr    = '0;
        port_A_we      = 1'b0;
        port_A_data_in = '0;
        done           = 1'b0;
        case (state_q)
            ST_RD_REQ, ST_RD_WAIT, ST_UNPACK: begin
                port_A_addr = ADDR_W'(rle_base_q + {sbyte_q[31:2], 2'b00});
            end
            ST_WR, ST_FLUSH: begin
                port_A_addr    = ADDR_W'(wr_addr_q);
                port_A_we      = 1'b1;
                port_A_data_in = pk_word;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign port_A_clk   = clk;
    assign message_size = out_cnt_q;

`ifdef RLE_DEC_ERR_CHECK_EN
    logic err_q, err_d;

    // Sticky error: odd size, zero count or output ceiling reached during this decode
    always_comb begin
        err_d = err_q;
        if (start_ok)
            err_d = rle_size[0];
        if (state_q == ST_UNPACK && have_cnt_q && cnt_q == 8'd0)
            err_d = 1'b1;
        if (state_q == ST_EXPAND && out_cnt_d == MAX_OUT)
            err_d = 1'b1;
    end

    // Error flag register
    always_ff @(posedge clk) begin
        if (!nreset) err_q <= 1'b0;
        else         err_q <= err_d;
    end

    assign error = err_q && (state_q == ST_DONE);
`endif

endmodule

// File: tb/tb_rle_decoder.sv
// tb/tb_rle_decoder.sv - directed table-driven bench for rle_decoder
module tb_rle_decoder;

    logic        clk = 1'b0;
    logic        nreset, start;
    logic [31:0] rle_addr, rle_size, message_addr, message_size;
    logic        done, port_A_clk, port_A_we;
    logic [15:0] port_A_addr;
    logic [31:0] port_A_data_in, port_A_data_out;
`ifdef RLE_DEC_ERR_CHECK_EN
    logic        error;
`endif

    always #5 clk = ~clk;

    rle_decoder #(.ADDR_W(16), .MAX_OUT_BYTES(65535)) dut (
        .clk             (clk),
        .nreset          (nreset),
        .start           (start),
        .rle_addr        (rle_addr),
        .rle_size        (rle_size),
        .message_addr    (message_addr),
        .message_size    (message_size),
        .done            (done),
        .port_A_clk      (port_A_clk),
        .port_A_addr     (port_A_addr),
        .port_A_we       (port_A_we),
        .port_A_data_in  (port_A_data_in),
        .port_A_data_out (port_A_data_out)
`ifdef RLE_DEC_ERR_CHECK_EN
        ,
        .error           (error)
`endif
    );

    logic [31:0] mem [0:16383];
    logic        ld_en = 1'b0;
    logic [15:0] ld_addr = '0;
    logic [31:0] ld_data = '0;
    int          wr_n = 0;

    always @(posedge clk) begin
        if (ld_en)
            mem[ld_addr[15:2]] <= ld_data;
        else if (port_A_we) begin
            mem[port_A_addr[15:2]] <= port_A_data_in;
            wr_n <= wr_n + 1;
        end
        port_A_data_out <= mem[port_A_addr[15:2]];
    end

    typedef struct {
        logic [31:0] w0;
        logic [31:0] w1;
        int          size;
        logic [31:0] msg;
        int          exp_size;
        int          nwr;
        logic [31:0] e0;
        logic [31:0] e1;
        logic        err;
    } vec_t;

    vec_t        vecs [8];
    int          n_pass = 0;
    int          n_total = 0;
    int          cyc, base, snap, bad;
    logic [31:0] m, expw;
    int          rc [6] = '{10, 6, 8, 1, 15, 8};
    logic [7:0]  rv [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    logic [7:0]  pt [48];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic load(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic pulse_start(input logic [31:0] ra, input logic [31:0] rs, input logic [31:0] ma);
        @(negedge clk);
        rle_addr = ra; rle_size = rs; message_addr = ma; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int c);
        c = 1;
        while (done !== 1'b1 && c < 3000) begin
            @(negedge clk);
            c++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'h42024103, 32'h0,        4, 32'h200, 5, 2, 32'h42414141, 32'h00000042, 1'b0};
        vecs[1] = '{32'h42024103, 32'h000000FF, 5, 32'h300, 5, 2, 32'h42414141, 32'h00000042, 1'b1};
        vecs[2] = '{32'h0000AB04, 32'h0,        2, 32'h480, 4, 1, 32'hABABABAB, 32'h0,        1'b0};
        vecs[3] = '{32'h41020000, 32'h0,        4, 32'h500, 2, 1, 32'h00004141, 32'h0,        1'b1};
        vecs[4] = '{32'h02020101, 32'h04010303, 8, 32'h580, 7, 2, 32'h03020201, 32'h00040303, 1'b0};
        vecs[5] = '{32'h00004105, 32'h0,        1, 32'h600, 0, 0, 32'h0,        32'h0,        1'b1};
        vecs[6] = '{32'h00004105, 32'h0,        0, 32'h680, 0, 0, 32'h0,        32'h0,        1'b0};
        vecs[7] = '{32'h22001102, 32'h00003303, 6, 32'h700, 5, 2, 32'h33331111, 32'h00000033, 1'b1};

        nreset = 1'b0; start = 1'b0;
        rle_addr = '0; rle_size = '0; message_addr = '0;
        repeat (3) @(negedge clk);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset we", {31'd0, port_A_we}, 32'd0);
        check("reset message_size", message_size, 32'd0);
        check("reset addr", {16'd0, port_A_addr}, 32'd0);
        check("reset data_in", port_A_data_in, 32'd0);
        nreset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            load(16'h100, vecs[i].w0);
            load(16'h104, vecs[i].w1);
            base = wr_n;
            m = vecs[i].msg;
            pulse_start(32'h100, vecs[i].size, m);
            wait_done(cyc);
            check($sformatf("v%0d done", i), {31'd0, done}, 32'd1);
            check($sformatf("v%0d message_size", i), message_size, vecs[i].exp_size);
            check($sformatf("v%0d writes", i), wr_n - base, vecs[i].nwr);
            if (vecs[i].nwr > 0) check($sformatf("v%0d word0", i), mem[m[15:2]], vecs[i].e0);
            if (vecs[i].nwr > 1) check($sformatf("v%0d word1", i), mem[m[15:2] + 14'd1], vecs[i].e1);
            if (vecs[i].size < 2) check($sformatf("v%0d short latency", i), {31'd0, cyc <= 2}, 32'd1);
`ifdef RLE_DEC_ERR_CHECK_EN
            check($sformatf("v%0d error", i), {31'd0, error}, {31'd0, vecs[i].err});
`endif
        end

        // Longest run, with an ignored start while busy
        load(16'h100, 32'h00005AFF);
        base = wr_n;
        pulse_start(32'h100, 32'd2, 32'h800);
        repeat (30) @(negedge clk);
        rle_size = 32'd0; message_addr = 32'h3000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy start ignored", {31'd0, done}, 32'd0);
        wait_done(cyc);
        check("run255 done", {31'd0, done}, 32'd1);
        check("run255 message_size", message_size, 32'd255);
        check("run255 writes", wr_n - base, 32'd64);
        bad = 0;
        for (int k = 0; k < 63; k++)
            if (mem[14'h200 + 14'(k)] !== 32'h5A5A5A5A) bad++;
        check("run255 full words bad", bad, 32'd0);
        check("run255 last word", mem[14'h23F], 32'h005A5A5A);

        // Reset pulsed during expansion
        pulse_start(32'h100, 32'd2, 32'h900);
        repeat (10) @(negedge clk);
        nreset = 1'b0;
        @(negedge clk);
        nreset = 1'b1;
        check("mid reset we", {31'd0, port_A_we}, 32'd0);
        check("mid reset done", {31'd0, done}, 32'd0);
        check("mid reset message_size", message_size, 32'd0);
        check("mid reset addr", {16'd0, port_A_addr}, 32'd0);
        snap = wr_n;
        repeat (4) @(negedge clk);
        check("no write after reset", wr_n - snap, 32'd0);
        check("no partial word", mem[14'h241], 32'd0);
        load(16'h100, 32'h42024103);
        base = wr_n;
        pulse_start(32'h100, 32'd4, 32'hA00);
        wait_done(cyc);
        check("post reset done", {31'd0, done}, 32'd1);
        check("post reset message_size", message_size, 32'd5);
        check("post reset writes", wr_n - base, 32'd2);
        check("post reset word0", mem[14'h280], 32'h42414141);
        check("post reset word1", mem[14'h281], 32'h00000042);

        // Round trip of a 48-byte frame from a 12-byte stream
        load(16'h00C8, 32'h2206110A);
        load(16'h00CC, 32'h44013308);
        load(16'h00D0, 32'h6608550F);
        begin
            int p;
            p = 0;
            for (int i = 0; i < 6; i++)
                for (int j = 0; j < rc[i]; j++) begin
                    pt[p] = rv[i];
                    p++;
                end
        end
        base = wr_n;
        pulse_start(32'hC8, 32'd12, 32'h400);
        wait_done(cyc);
        check("frame done", {31'd0, done}, 32'd1);
        check("frame message_size", message_size, 32'd48);
        check("frame writes", wr_n - base, 32'd12);
        for (int k = 0; k < 12; k++) begin
            expw = {pt[4*k+3], pt[4*k+2], pt[4*k+1], pt[4*k]};
            check($sformatf("frame word%0d", k), mem[14'h100 + 14'(k)], expw);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
